ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter CALC_CYCLES, default 32, number of iteration cycles per multiply/divide.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  HI/LO-class instruction present in EX; 0 for bubbles and flushed slots.
REQ-005 SHALL have port i_op  input  3  operation: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-006 SHALL have port i_data_1  input  32  forwarded rs operand: multiplicand/dividend, or MTHI/MTLO source.
REQ-007 SHALL have port i_data_2  input  32  forwarded rt operand: multiplier/divisor.
REQ-008 SHALL have port o_stall  output  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
REQ-009 SHALL have port o_busy  output  1  registered; high whenever state is not IDLE.
REQ-010 SHALL have port o_result  output  32  MFHI/MFLO read data to EX result mux.

Function
REQ-011 SHALL implement states IDLE, CALC and FIX.
REQ-012 SHALL, in IDLE with i_valid and a MULT/MULTU/DIV/DIVU op, latch the operands, the signedness and the op kind, load the counter with CALC_CYCLES-1 and enter CALC; o_stall SHALL stay 0 that cycle.
REQ-013 SHALL perform one iteration per cycle in CALC: shift-add for multiply, restoring shift-subtract for divide; both SHALL operate on 32-bit magnitudes with a 64-bit accumulator.
REQ-014 SHALL move from CALC to FIX when the counter reaches 0; the counter SHALL NOT wrap.
REQ-015 SHALL, in FIX, apply the sign correction and write HI/LO, then return to IDLE. An op accepted at edge k therefore updates HI/LO at edge k+CALC_CYCLES+1.
REQ-016 Signed multiply SHALL produce the two's-complement 64-bit product when operand signs differ; HI is bits 63:32 and LO is bits 31:0.
REQ-017 Divide SHALL put the quotient in LO and the remainder in HI; a signed quotient is negative iff operand signs differ, and the signed remainder takes the sign of the dividend.
REQ-018 Divide by zero SHALL give LO=0xFFFFFFFF and HI=dividend, for both signed and unsigned divide.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 o_stall SHALL equal i_valid AND (state != IDLE) and SHALL be combinational; any HI/LO instruction reaching EX, including another mult/div, waits until IDLE.
REQ-021 o_result SHALL be combinational: HI for MFHI, LO for MFLO, 0 otherwise; it is valid only when o_stall=0.
REQ-022 MTHI/MTLO in IDLE SHALL write HI or LO from i_data_1 at the clock edge; a same-cycle MFHI/MFLO is impossible because EX holds one instruction.
REQ-023 Instructions without i_valid SHALL flow through EX unaffected while the unit is busy.
REQ-024 An accepted operation SHALL always complete; there is no abort input.
REQ-025 Operand inputs SHALL be ignored outside the accept cycle.

Reset
REQ-026 On reset the block SHALL force state=IDLE, counter=0, HI=0, LO=0, all operand, accumulator and sign registers to 0, and o_busy=0; o_stall and o_result then evaluate to 0.
REQ-027 Reset asserted mid-CALC or mid-FIX SHALL discard the operation with no HI/LO write.

Structure
REQ-028 The i_op encodings and the state encodings SHALL live in the shared pipeline constants package, which the decoder also uses.
REQ-029 The block SHALL contain one sub-module, muldiv_iter_core, holding the counter, the accumulator and the per-cycle datapath; ex_muldiv_unit holds the FSM, HI/LO, stall logic and sign fix-up.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_busy high for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 MULT 6x7 followed next cycle by MFLO -> o_stall high for exactly 33 cycles, then o_result=42; an interleaved ADD with i_valid=0 shows no stall.
REQ-034 Reset pulsed at CALC cycle 10 of MULT 2x3, then MFLO -> o_stall=0 and o_result=0; MTLO 0x1234 followed by MFLO -> 0x1234.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared pipeline constants for the EX-stage HI/LO multiply/divide unit:
// op and state encodings, operand context record and a magnitude helper.
package ex_muldiv_unit_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ACC_W = 2 * XLEN;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MFHI  = 3'd4,
      OP_MFLO  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   // Raw operands and op kind captured at accept, needed again for sign fix-up
   typedef struct packed {
      logic            is_div;
      logic            is_signed;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } md_ctx_t;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
      return (is_signed && x[XLEN-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface ex_muldiv_unit_if;
   import ex_muldiv_unit_pkg::*;

   logic            i_valid;
   md_op_e          i_op;
   logic [XLEN-1:0] i_data_1;
   logic [XLEN-1:0] i_data_2;
   logic            o_stall;
   logic            o_busy;
   logic [XLEN-1:0] o_result;

   modport master (
      output i_valid, i_op, i_data_1, i_data_2,
      input  o_stall, o_busy, o_result
   );

   modport slave (
      input  i_valid, i_op, i_data_1, i_data_2,
      output o_stall, o_busy, o_result
   );
endinterface

// File: rtl/ex_muldiv_unit_iter.sv
// muldiv_iter_core: iteration counter, 64-bit accumulator and the one-step
// shift-add multiply / restoring shift-subtract divide datapath on magnitudes.
module muldiv_iter_core
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned CALC_CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic             is_div,
   input  logic [XLEN-1:0]  mag_a,
   input  logic [XLEN-1:0]  mag_b,
   output logic             done,
   output logic [ACC_W-1:0] acc
);

   localparam int unsigned CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [XLEN-1:0]  opb_q;
   logic             div_q;
   logic [XLEN:0]    add_sum;
   logic [XLEN:0]    sub_rem;
   logic [XLEN:0]    sub_trial;

   // Divide: upper half is the partial remainder, quotient bits shift in at the bottom.
   // Multiply: multiplier bits shift out at the bottom, product grows from the top.
   always_comb begin
      add_sum   = '0;
      sub_rem   = '0;
      sub_trial = '0;
      acc_d     = acc_q;
      if (div_q) begin
         sub_rem   = acc_q[ACC_W-1:XLEN-1];
         sub_trial = sub_rem - {1'b0, opb_q};
         if (!sub_trial[XLEN])
            acc_d = {sub_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         else
            acc_d = {sub_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         add_sum = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : XLEN'(0))};
         acc_d   = {add_sum, acc_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         acc_q <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
      end else if (start) begin
         cnt_q <= CNT_W'(CALC_CYCLES - 1);
         acc_q <= {XLEN'(0), mag_a};
         opb_q <= mag_b;
         div_q <= is_div;
      end else if (step) begin
         acc_q <= acc_d;
         if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign done = (cnt_q == '0);
   assign acc  = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: accept FSM, HI/LO registers, pipeline stall and
// sign fix-up around the iterative multiply/divide core.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned CALC_CYCLES = 32
) (
   input logic              clk,
   input logic              reset,
   ex_muldiv_unit_if.slave  bus
);

   md_state_e        state_q;
   logic             busy_q;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;
   md_ctx_t          ctx_q;

   logic             is_md_op;
   logic             op_signed;
   logic             op_div;
   logic             accept;
   logic             core_done;
   logic [ACC_W-1:0] core_acc;
   logic [XLEN-1:0]  fix_hi;
   logic [XLEN-1:0]  fix_lo;

   assign is_md_op  = bus.i_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   assign op_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
   assign op_div    = (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
   assign accept    = bus.i_valid && is_md_op && (state_q == ST_IDLE);

   muldiv_iter_core #(.CALC_CYCLES(CALC_CYCLES)) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .step   (state_q == ST_CALC),
      .is_div (op_div),
      .mag_a  (mag(bus.i_data_1, op_signed)),
      .mag_b  (mag(bus.i_data_2, op_signed)),
      .done   (core_done),
      .acc    (core_acc)
   );

   // Divide by zero bypasses the magnitude result so the dividend survives unsigned
   always_comb begin
      fix_hi = core_acc[ACC_W-1:XLEN];
      fix_lo = core_acc[XLEN-1:0];
      if (ctx_q.is_div) begin
         if (ctx_q.b == '0) begin
            fix_lo = '1;
            fix_hi = ctx_q.a;
         end else if (ctx_q.is_signed) begin
            if (ctx_q.a[XLEN-1] ^ ctx_q.b[XLEN-1])
               fix_lo = -core_acc[XLEN-1:0];
            if (ctx_q.a[XLEN-1])
               fix_hi = -core_acc[ACC_W-1:XLEN];
         end
      end else if (ctx_q.is_signed && (ctx_q.a[XLEN-1] ^ ctx_q.b[XLEN-1])) begin
         {fix_hi, fix_lo} = -core_acc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         ctx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ctx_q   <= '{is_div: op_div, is_signed: op_signed,
                               a: bus.i_data_1, b: bus.i_data_2};
                  state_q <= ST_CALC;
                  busy_q  <= 1'b1;
               end else if (bus.i_valid && (bus.i_op == OP_MTHI)) begin
                  hi_q <= bus.i_data_1;
               end else if (bus.i_valid && (bus.i_op == OP_MTLO)) begin
                  lo_q <= bus.i_data_1;
               end
            end
            ST_CALC: begin
               if (core_done)
                  state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_stall  = bus.i_valid && (state_q != ST_IDLE);
   assign bus.o_result = (bus.i_op == OP_MFHI) ? hi_q :
                         (bus.i_op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, randomized ops
// against an arithmetic reference, and stall/reset/MTxx sequences.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   localparam int unsigned CALC_CYCLES = 32;
   localparam int unsigned WAIT_MAX    = 200;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_muldiv_unit_if bus();

   ex_muldiv_unit #(.CALC_CYCLES(CALC_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      md_op_e      op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural HI/LO results computed with plain integer arithmetic
   function automatic void ref_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      int          sa;
      int          sb;
      longint      sp;
      logic [63:0] p;
      sa = a;
      sb = b;
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT: begin
            sp = longint'(sa) * longint'(sb);
            p  = sp;
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULTU: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else begin
               lo = sa / sb;
               hi = sa % sb;
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one mult/div, scramble operands while busy, then read HI/LO back
   task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output logic [31:0] hi, output logic [31:0] lo);
      int n;
      bus.i_valid  = 1'b1;
      bus.i_op     = op;
      bus.i_data_1 = a;
      bus.i_data_2 = b;
      #1;
      check({tag, "_accept_stall"}, 32'(bus.o_stall), 32'd0);
      tick();
      bus.i_valid  = 1'b0;
      bus.i_data_1 = $urandom;
      bus.i_data_2 = $urandom;
      n = 0;
      while (bus.o_busy && n < WAIT_MAX) begin
         n++;
         tick();
         bus.i_data_1 = $urandom;
         bus.i_data_2 = $urandom;
      end
      check({tag, "_busy_cycles"}, 32'(n), 32'(CALC_CYCLES + 1));
      bus.i_valid = 1'b1;
      bus.i_op    = OP_MFHI;
      #1;
      hi = bus.o_result;
      bus.i_op = OP_MFLO;
      #1;
      lo = bus.o_result;
      bus.i_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[10];
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] ehi;
      logic [31:0] elo;
      md_op_e      op;
      logic [31:0] a;
      logic [31:0] b;
      int          n;

      vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
      vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
      vecs[9] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

      // Reset state
      reset        = 1'b1;
      bus.i_valid  = 1'b1;
      bus.i_op     = OP_MFLO;
      bus.i_data_1 = 32'hDEAD_BEEF;
      bus.i_data_2 = 32'h1234_5678;
      tick();
      tick();
      check("reset_busy",   32'(bus.o_busy),  32'd0);
      check("reset_stall",  32'(bus.o_stall), 32'd0);
      check("reset_mflo",   bus.o_result,     32'd0);
      bus.i_op = OP_MFHI;
      #1;
      check("reset_mfhi",   bus.o_result,     32'd0);
      bus.i_valid = 1'b0;
      reset = 1'b0;
      tick();

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), hi, lo);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         tick();
      end

      // Randomized ops against the reference model
      for (int i = 0; i < 24; i++) begin
         op = md_op_e'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         ref_model(op, a, b, ehi, elo);
         run_op(op, a, b, $sformatf("rnd%0d", i), hi, lo);
         check($sformatf("rnd%0d_op%0d_hi", i, op), hi, ehi);
         check($sformatf("rnd%0d_op%0d_lo", i, op), lo, elo);
         tick();
      end

      // MULT 6x7 with MFLO right behind it: stall for the whole operation
      bus.i_valid  = 1'b1;
      bus.i_op     = OP_MULT;
      bus.i_data_1 = 32'd6;
      bus.i_data_2 = 32'd7;
      tick();
      bus.i_op = OP_MFLO;
      #1;
      n = 0;
      while (bus.o_stall && n < WAIT_MAX) begin
         n++;
         tick();
      end
      check("mflo_stall_cycles", 32'(n), 32'(CALC_CYCLES + 1));
      check("mflo_after_stall",  bus.o_result, 32'd42);
      bus.i_valid = 1'b0;
      tick();

      // Non-HI/LO instruction (i_valid=0) passes while busy
      bus.i_valid  = 1'b1;
      bus.i_op     = OP_MULT;
      bus.i_data_1 = 32'd3;
      bus.i_data_2 = 32'd5;
      tick();
      bus.i_valid = 1'b0;
      tick();
      check("bubble_busy",  32'(bus.o_busy),  32'd1);
      check("bubble_stall", 32'(bus.o_stall), 32'd0);
      n = 0;
      while (bus.o_busy && n < WAIT_MAX) begin
         n++;
         tick();
      end
      bus.i_valid = 1'b1;
      bus.i_op    = OP_MFLO;
      #1;
      check("bubble_mflo", bus.o_result, 32'd15);
      bus.i_valid = 1'b0;
      tick();

      // Reset mid-CALC discards the operation
      bus.i_valid  = 1'b1;
      bus.i_op     = OP_MULT;
      bus.i_data_1 = 32'd2;
      bus.i_data_2 = 32'd3;
      tick();
      bus.i_valid = 1'b0;
      repeat (10) tick();
      check("midcalc_busy", 32'(bus.o_busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_busy", 32'(bus.o_busy), 32'd0);
      #1 reset = 1'b0;
      tick();
      bus.i_valid = 1'b1;
      bus.i_op    = OP_MFLO;
      #1;
      check("post_reset_stall", 32'(bus.o_stall), 32'd0);
      check("post_reset_mflo",  bus.o_result,     32'd0);
      bus.i_valid = 1'b0;
      repeat (40) tick();
      check("discard_busy", 32'(bus.o_busy), 32'd0);
      bus.i_valid = 1'b1;
      bus.i_op    = OP_MFHI;
      #1;
      check("discard_mfhi", bus.o_result, 32'd0);

      // MTLO / MTHI write-through
      bus.i_op     = OP_MTLO;
      bus.i_data_1 = 32'h0000_1234;
      tick();
      bus.i_op = OP_MFLO;
      #1;
      check("mtlo_mflo", bus.o_result, 32'h0000_1234);
      bus.i_op     = OP_MTHI;
      bus.i_data_1 = 32'hABCD_0000;
      tick();
      bus.i_op = OP_MFHI;
      #1;
      check("mthi_mfhi", bus.o_result, 32'hABCD_0000);
      bus.i_op = OP_MFLO;
      #1;
      check("mthi_keeps_lo", bus.o_result, 32'h0000_1234);
      bus.i_op = OP_MULTU;
      bus.i_valid = 1'b0;
      #1;
      check("non_mf_result", bus.o_result, 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
